// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, defaults and sizing helpers for the instruction
//               fetch / prefetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int                FETCH_ADDRESS_WIDTH = 32;
   localparam int                FETCH_INSTR_WIDTH   = 32;
   localparam int                FETCH_DEPTH         = 4;
   localparam logic [31:0]       FETCH_RESET_PC      = 32'h0000_0000;

   // One prefetch-queue entry at the default widths: the instruction and the
   // PC+4 of the address it was fetched from.
   typedef struct packed {
      logic [FETCH_INSTR_WIDTH-1:0]   instr;
      logic [FETCH_ADDRESS_WIDTH-1:0] pc_plus4;
   } fetch_entry_t;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int fetch_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with push/pop/flush and occupancy count.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_Flush,
   input  logic                     i_Push,
   input  logic                     i_Pop,
   input  logic [WIDTH-1:0]         i_Data,
   output logic [WIDTH-1:0]         o_Data,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count
);

   localparam int                c_PW        = $clog2(DEPTH);
   localparam logic [c_PW:0]     c_DEPTH_CNT = (c_PW + 1)'(DEPTH);
   localparam logic [c_PW-1:0]   c_PTR_ONE   = c_PW'(1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PW-1:0]    r_wr_ptr;
   logic [c_PW-1:0]    r_rd_ptr;
   logic [c_PW:0]      r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_Empty   = (r_count == '0);
   assign o_Full    = (r_count == c_DEPTH_CNT);
   assign o_Count   = r_count;
   assign o_Data    = r_mem[r_rd_ptr];
   // A pop from a full queue frees the slot the simultaneous push needs.
   assign w_do_pop  = i_Pop & ~o_Empty & ~i_Flush;
   assign w_do_push = i_Push & ~i_Flush & (~o_Full | w_do_pop);

   // Storage array: written only on an accepted push, never reset.
   always_ff @(posedge i_CLK) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_Data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties without touching data.
   always_ff @(posedge i_CLK) begin
      if (i_RST || i_Flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_count <= r_count + (c_PW + 1)'(w_do_push) - (c_PW + 1)'(w_do_pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_stage
// Description : Instruction fetch stage with a run-ahead PC, a handshaked
//               memory request port and an in-order prefetch queue. Decode
//               redirects flush the queue and drop in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_stage
   import fetch_pkg::*;
#(
   parameter int                        ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
   parameter int                        INSTR_WIDTH   = FETCH_INSTR_WIDTH,
   parameter int                        DEPTH         = FETCH_DEPTH,
   parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = ADDRESS_WIDTH'(FETCH_RESET_PC)
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic [ADDRESS_WIDTH-1:0]  i_PCD,
   input  logic                      i_PCSrcD,
   input  logic                      i_StallD,
   output logic                      o_ReqValid,
   output logic [ADDRESS_WIDTH-1:0]  o_ReqAddr,
   input  logic                      i_ReqReady,
   input  logic                      i_RespValid,
   input  logic [INSTR_WIDTH-1:0]    i_RespInstr,
   output logic                      o_ValidF,
   output logic [INSTR_WIDTH-1:0]    o_InstrF,
   output logic [ADDRESS_WIDTH-1:0]  o_PCPlus4F
);

   localparam int                        c_CW        = fetch_cnt_width(DEPTH);
   localparam logic [c_CW:0]             c_DEPTH_EXT = (c_CW + 1)'(DEPTH);
   localparam logic [c_CW-1:0]           c_CNT_ONE   = c_CW'(1);
   localparam logic [ADDRESS_WIDTH-1:0]  c_PC_STEP   = ADDRESS_WIDTH'(4);

   typedef struct packed {
      logic [INSTR_WIDTH-1:0]   instr;
      logic [ADDRESS_WIDTH-1:0] pc_plus4;
   } entry_t;

   logic [ADDRESS_WIDTH-1:0]  r_pcf;       // next address to request
   logic [ADDRESS_WIDTH-1:0]  r_resp_pc;   // PC of the next useful response
   logic [c_CW-1:0]           r_outst;     // accepted, not yet answered
   logic [c_CW-1:0]           r_drop;      // answers still to be discarded
   logic [c_CW-1:0]           w_occ;
   logic                      w_empty;
   logic                      w_full;
   logic                      w_credit_ok;
   logic                      w_req_fire;
   logic                      w_resp_ok;
   logic                      w_push;
   logic                      w_pop;
   entry_t                    w_push_entry;
   entry_t                    w_head;

   // Queue slots plus outstanding requests never exceed DEPTH, so every
   // response that is kept is guaranteed a free slot.
   assign w_credit_ok  = ({1'b0, w_occ} + {1'b0, r_outst}) < c_DEPTH_EXT;
   assign o_ReqValid   = ~i_RST & ~i_PCSrcD & w_credit_ok;
   assign o_ReqAddr    = r_pcf;
   assign w_req_fire   = o_ReqValid & i_ReqReady;

   // A response with nothing outstanding is a stray (e.g. from before a
   // reset) and is ignored entirely.
   assign w_resp_ok    = i_RespValid & (r_outst != '0);
   assign w_push       = w_resp_ok & (r_drop == '0) & ~i_PCSrcD & (~w_full | w_pop);
   assign w_pop        = ~w_empty & ~i_StallD & ~i_PCSrcD;

   assign w_push_entry.instr    = i_RespInstr;
   assign w_push_entry.pc_plus4 = r_resp_pc + c_PC_STEP;

   sync_fifo #(
      .WIDTH (INSTR_WIDTH + ADDRESS_WIDTH),
      .DEPTH (DEPTH)
   ) u_prefetch_q (
      .i_CLK   (i_CLK),
      .i_RST   (i_RST),
      .i_Flush (i_PCSrcD),
      .i_Push  (w_push),
      .i_Pop   (w_pop),
      .i_Data  (w_push_entry),
      .o_Data  (w_head),
      .o_Full  (w_full),
      .o_Empty (w_empty),
      .o_Count (w_occ)
   );

   // Head presentation: zeroed whenever the queue holds nothing valid.
   assign o_ValidF   = ~w_empty;
   assign o_InstrF   = w_empty ? '0 : w_head.instr;
   assign o_PCPlus4F = w_empty ? '0 : w_head.pc_plus4;

   // Issue and response PCs: redirect reloads both, otherwise each steps by 4.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_pcf     <= RESET_PC;
         r_resp_pc <= RESET_PC;
      end else if (i_PCSrcD) begin
         r_pcf     <= i_PCD;
         r_resp_pc <= i_PCD;
      end else begin
         if (w_req_fire) begin
            r_pcf <= r_pcf + c_PC_STEP;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + c_PC_STEP;
         end
      end
   end

   // Outstanding and drop counters; a redirect turns every request still in
   // flight after this cycle's response into one to be discarded.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_outst <= '0;
         r_drop  <= '0;
      end else begin
         r_outst <= r_outst + c_CW'(w_req_fire) - c_CW'(w_resp_ok);
         if (i_PCSrcD) begin
            r_drop <= r_outst - c_CW'(w_resp_ok);
         end else if (w_resp_ok && (r_drop != '0)) begin
            r_drop <= r_drop - c_CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire
